// File: rtl/l3_pkg.sv
// l3_pkg: shared types and helpers for the L3 fill responder.
//   l3_state_t    responder FSM states
//   L3_NO_DATA    sentinel driven on the response bus when no response is valid
//   BE_*          supported byte-enable encodings (byte, half, word)
//   merge_bytes   replaces the enabled bytes of a word
//   be_supported  1 when a byte-enable pattern is one of the supported encodings
package l3_pkg;

   localparam int L3_DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MEM_REQ,
      MEM_WAIT,
      RESP
   } l3_state_t;

   localparam logic [31:0] L3_NO_DATA = 32'hDEADBEEF;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

   function automatic logic be_supported(input logic [3:0] be);
      return (be == BE_BYTE) || (be == BE_HALF) || (be == BE_WORD);
   endfunction

endpackage

// File: rtl/l3_fill_responder_if.sv
// l3_fill_responder_if: L2-facing request/response bus plus the main-memory
// request/response bus of the L3 fill responder.
//   slave  : view taken by the responder (accepts L2 requests, drives memory requests)
//   master : view taken by the surrounding L2 / memory model
interface l3_fill_responder_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    req_valid_i;
   logic                    req_ready_o;
   logic [ADDR_WIDTH-1:0]   req_addr_i;
   logic                    req_wr_en_i;
   logic [DATA_WIDTH-1:0]   req_wr_data_i;
   logic [DATA_WIDTH/8-1:0] req_byte_en_i;
   logic                    rsp_valid_o;
   logic [DATA_WIDTH-1:0]   l3_cache_data_o;
   logic                    rsp_err_o;
   logic                    mem_req_valid_o;
   logic                    mem_req_ready_i;
   logic [ADDR_WIDTH-1:0]   mem_addr_o;
   logic                    mem_wr_en_o;
   logic [DATA_WIDTH-1:0]   mem_wr_data_o;
   logic [DATA_WIDTH/8-1:0] mem_byte_en_o;
   logic                    mem_rsp_valid_i;
   logic [DATA_WIDTH-1:0]   mem_rd_data_i;

   modport slave (
      input  req_valid_i, req_addr_i, req_wr_en_i, req_wr_data_i, req_byte_en_i,
             mem_req_ready_i, mem_rsp_valid_i, mem_rd_data_i,
      output req_ready_o, rsp_valid_o, l3_cache_data_o, rsp_err_o,
             mem_req_valid_o, mem_addr_o, mem_wr_en_o, mem_wr_data_o, mem_byte_en_o
   );

   modport master (
      output req_valid_i, req_addr_i, req_wr_en_i, req_wr_data_i, req_byte_en_i,
             mem_req_ready_i, mem_rsp_valid_i, mem_rd_data_i,
      input  req_ready_o, rsp_valid_o, l3_cache_data_o, rsp_err_o,
             mem_req_valid_o, mem_addr_o, mem_wr_en_o, mem_wr_data_o, mem_byte_en_o
   );
endinterface

// File: rtl/l3_tag_data_array.sv
// l3_tag_data_array: direct-mapped tag/data/valid storage, one word per line.
//   clk, rst   clock; synchronous active-high reset clears every valid bit
//   idx, tag   line selected for both lookup and write
//   hit        line valid and stored tag equals tag (combinational)
//   rd_word    stored word of the selected line (combinational)
//   wr_en      writes wr_word and tag into the line and marks it valid
module l3_tag_data_array #(
   parameter int NUM_LINES  = 1024,
   parameter int INDEX_BITS = $clog2(NUM_LINES),
   parameter int TAG_BITS   = 22,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] idx,
   input  logic [TAG_BITS-1:0]   tag,
   output logic                  hit,
   output logic [DATA_WIDTH-1:0] rd_word,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_word
);
   logic [NUM_LINES-1:0]  valid_q;
   logic [TAG_BITS-1:0]   tag_mem  [NUM_LINES];
   logic [DATA_WIDTH-1:0] data_mem [NUM_LINES];

   assign hit     = valid_q[idx] && (tag_mem[idx] == tag);
   assign rd_word = data_mem[idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[idx] <= 1'b1;
      end
   end

   // tag/data carry no reset; valid gates every use of them
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         tag_mem[idx]  <= tag;
         data_mem[idx] <= wr_word;
      end
   end
endmodule

// File: rtl/l3_fill_responder.sv
// l3_fill_responder: direct-mapped L3 word store serving one L2 request at a
// time, write-through / no-write-allocate toward main memory.
//   clk, rst       clock; synchronous active-high reset
//   bus (slave)    L2 request/response and main-memory request/response
//   hit_count_o    (L3_STATS_EN only) supported lookups that hit
//   miss_count_o   (L3_STATS_EN only) supported lookups that missed
// Optional feature macro: L3_STATS_EN adds the hit/miss counters.
//
// state    | meaning
// IDLE     | ready for an L2 request
// LOOKUP   | tag compare; write hit merges into the line here
// MEM_REQ  | memory request held until accepted
// MEM_WAIT | waiting for read data / write ack; read fills the line
// RESP     | one-cycle response strobe
module l3_fill_responder
   import l3_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = L3_DATA_WIDTH,
   parameter int NUM_LINES  = 1024
) (
   input logic clk,
   input logic rst,
   l3_fill_responder_if.slave bus
`ifdef L3_STATS_EN
   ,
   output logic [31:0] hit_count_o,
   output logic [31:0] miss_count_o
`endif
);
   localparam int INDEX_BITS = $clog2(NUM_LINES);
   localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS;

   l3_state_t state_q, state_d;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  we_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [3:0]            be_q;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  rsp_err_q, rsp_err_d;

   logic [INDEX_BITS-1:0] idx;
   logic [TAG_BITS-1:0]   tag;
   logic                  hit;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  arr_wr_en;
   logic [DATA_WIDTH-1:0] arr_wr_word;
   logic                  handshake;

   assign handshake = (state_q == IDLE) && bus.req_valid_i;

   // low address bits belong to the tag, so a different byte offset is a miss
   assign idx = addr_q[INDEX_BITS+1:2];
   assign tag = {addr_q[ADDR_WIDTH-1:INDEX_BITS+2], addr_q[1:0]};

   l3_tag_data_array #(
      .NUM_LINES (NUM_LINES),
      .INDEX_BITS(INDEX_BITS),
      .TAG_BITS  (TAG_BITS),
      .DATA_WIDTH(DATA_WIDTH)
   ) u_array (
      .clk    (clk),
      .rst    (rst),
      .idx    (idx),
      .tag    (tag),
      .hit    (hit),
      .rd_word(rd_word),
      .wr_en  (arr_wr_en),
      .wr_word(arr_wr_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rsp_data_q <= L3_NO_DATA;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         be_q    <= '0;
      end else if (handshake) begin
         addr_q  <= bus.req_addr_i;
         we_q    <= bus.req_wr_en_i;
         wdata_q <= bus.req_wr_data_i;
         be_q    <= bus.req_byte_en_i;
      end
   end

   always_comb begin
      state_d     = state_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      arr_wr_en   = 1'b0;
      arr_wr_word = rd_word;
      case (state_q)
         IDLE: begin
            if (bus.req_valid_i) state_d = LOOKUP;
         end
         LOOKUP: begin
            rsp_err_d = 1'b0;
            if (!be_supported(be_q)) begin
               rsp_err_d  = 1'b1;
               rsp_data_d = L3_NO_DATA;
               state_d    = RESP;
            end else if (!we_q) begin
               if (hit) begin
                  rsp_data_d = rd_word;
                  state_d    = RESP;
               end else begin
                  state_d = MEM_REQ;
               end
            end else begin
               if (hit) begin
                  arr_wr_en   = 1'b1;
                  arr_wr_word = merge_bytes(rd_word, wdata_q, be_q);
                  rsp_data_d  = arr_wr_word;
               end else begin
                  rsp_data_d = merge_bytes('0, wdata_q, be_q);
               end
               state_d = MEM_REQ;
            end
         end
         MEM_REQ: begin
            // a response in the same cycle as the accept is not ours yet
            if (bus.mem_req_ready_i) state_d = MEM_WAIT;
         end
         MEM_WAIT: begin
            if (bus.mem_rsp_valid_i) begin
               if (!we_q) begin
                  arr_wr_en   = 1'b1;
                  arr_wr_word = bus.mem_rd_data_i;
                  rsp_data_d  = bus.mem_rd_data_i;
               end
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.req_ready_o     = (state_q == IDLE);
   assign bus.rsp_valid_o     = (state_q == RESP);
   assign bus.l3_cache_data_o = bus.rsp_valid_o ? rsp_data_q : L3_NO_DATA;
   assign bus.rsp_err_o       = bus.rsp_valid_o && rsp_err_q;

   assign bus.mem_req_valid_o = (state_q == MEM_REQ);
   assign bus.mem_addr_o      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign bus.mem_wr_en_o     = we_q;
   assign bus.mem_wr_data_o   = wdata_q;
   assign bus.mem_byte_en_o   = be_q;

`ifdef L3_STATS_EN
   logic lookup_counted;
   assign lookup_counted = (state_q == LOOKUP) && be_supported(be_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count_o  <= '0;
         miss_count_o <= '0;
      end else if (lookup_counted) begin
         if (hit) hit_count_o  <= hit_count_o + 32'd1;
         else     miss_count_o <= miss_count_o + 32'd1;
      end
   end
`endif
endmodule
